mem_commit_queue: RTL and testbench

- In-order memory commit stage directly downstream of the reorder buffer.
- Accepts committed stores (address, data) and committed loads (address, tag, destination register) from the ROB memory-commit outputs.
- Buffers them in a small FIFO and issues them one at a time to the data-cache port.
- Broadcasts load results to the register file / reservation stations. Drives the CacheReady back-pressure consumed by the ROB.

---
 rtl/mem_commit_pkg.sv | 23 ++
 rtl/commit_fifo.sv | 72 +++++++
 rtl/mem_commit_queue.sv | 200 ++++++++++++++++++++
 tb/tb_mem_commit_queue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_commit_pkg.sv
// Shared types for the in-order memory commit queue: FIFO entry layout,
// commit FSM encoding and ROB-side field widths.
package mem_commit_pkg;

   localparam int TAG_W  = 4;
   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic              is_store;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
      logic [REG_W-1:0]  wreg;
   } entry_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/commit_fifo.sv
// Commit FIFO: up to two pushes per cycle (slot 0 is older), one pop, and
// head/second-entry visibility so the FSM can reload the next request on a pop.
module commit_fifo
   import mem_commit_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push0,
   input  entry_t                   i_din0,
   input  logic                     i_push1,
   input  entry_t                   i_din1,
   input  logic                     i_pop,
   output entry_t                   o_head,
   output entry_t                   o_second,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_almost_full,
   output logic                     o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic [CW-1:0]   w_free;
   logic            w_acc0;
   logic            w_acc1;
   logic            w_pop_ok;
   logic [PW-1:0]   w_wr_ptr1;

   // Space is judged before this cycle's pop so a push never depends on the pop.
   assign w_free    = CW'(DEPTH) - r_count;
   assign w_acc0    = i_push0 && (w_free != '0);
   assign w_acc1    = i_push1 && (w_free > (w_acc0 ? CW'(1) : CW'(0)));
   assign w_pop_ok  = i_pop && (r_count != '0);
   assign w_wr_ptr1 = w_acc0 ? (r_wr_ptr + PW'(1)) : r_wr_ptr;

   always_ff @(posedge clk) begin
      if (w_acc0) r_mem[r_wr_ptr]  <= i_din0;
      if (w_acc1) r_mem[w_wr_ptr1] <= i_din1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PW'(w_acc0) + PW'(w_acc1);
         if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count  <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop_ok);
      end
   end

   assign o_head        = r_mem[r_rd_ptr];
   assign o_second      = r_mem[r_rd_ptr + PW'(1)];
   assign o_count       = r_count;
   assign o_full        = (r_count == CW'(DEPTH));
   assign o_almost_full = (r_count >= CW'(DEPTH - 1));
   assign o_empty       = (r_count == '0);

   // A dropped enqueue means the ROB ignored CacheReady.
   assert property (@(posedge clk) disable iff (!rst_n)
      !((i_push0 && !w_acc0) || (i_push1 && !w_acc1)));

endmodule

// File: rtl/mem_commit_queue.sv
// In-order memory commit stage: queues committed loads/stores, issues them to
// the data cache one at a time. Optional store-to-load forwarding: MEM_COMMIT_STORE_FWD_EN.
module mem_commit_queue
   import mem_commit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32
)(
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   ROBMWE,
   input  logic [AW-1:0]          ROBMWA,
   input  logic [AW-1:0]          ROBMWD,
   input  logic                   ROBMRegWrite,
   input  logic [AW-1:0]          ROBMRA,
   input  logic [TAG_W-1:0]       ROBMTag,
   input  logic [REG_W-1:0]       ROBMWriteReg,
   output logic                   CacheReady,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [AW-1:0]          mem_addr,
   output logic [AW-1:0]          mem_wdata,
   input  logic                   mem_gnt,
   input  logic                   mem_rvalid,
   input  logic [AW-1:0]          mem_rdata,
   output logic [TAG_W-1:0]       LdTag,
   output logic [AW-1:0]          LdResult,
   output logic [REG_W-1:0]       LdWriteReg,
   output logic                   LdRegWrite,
   output logic [$clog2(DEPTH):0] q_count
);

   localparam int CW = $clog2(DEPTH) + 1;

   entry_t          w_st_entry;
   entry_t          w_ld_entry;
   entry_t          w_head;
   entry_t          w_second;
   entry_t          w_nxt;
   logic [CW-1:0]   w_count;
   logic            w_full;
   logic            w_afull;
   logic            w_empty;
   logic            w_pop;
   logic            w_issue;
   logic            w_hit;

   state_t          r_state;
   logic            r_mem_req;
   logic            r_mem_we;
   logic [AW-1:0]   r_mem_addr;
   logic [AW-1:0]   r_mem_wdata;
   logic            r_ld_regwrite;
   logic [TAG_W-1:0] r_ld_tag;
   logic [REG_W-1:0] r_ld_wreg;
   logic [AW-1:0]   r_ld_result;

   assign w_st_entry = '{is_store: 1'b1, addr: ROBMWA, data: ROBMWD, tag: '0, wreg: '0};
   assign w_ld_entry = '{is_store: 1'b0, addr: ROBMRA, data: '0, tag: ROBMTag, wreg: ROBMWriteReg};

   commit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk           (CLK),
      .rst_n         (reset),
      .i_push0       (ROBMWE),
      .i_din0        (w_st_entry),
      .i_push1       (ROBMRegWrite),
      .i_din1        (w_ld_entry),
      .i_pop         (w_pop),
      .o_head        (w_head),
      .o_second      (w_second),
      .o_count       (w_count),
      .o_full        (w_full),
      .o_almost_full (w_afull),
      .o_empty       (w_empty)
   );

`ifdef MEM_COMMIT_STORE_FWD_EN
   logic            r_ls_valid;
   logic [AW-1:0]   r_ls_addr;
   logic [AW-1:0]   r_ls_data;
   logic            r_fwd;
   logic            w_st_grant;
   logic            w_ls_valid;
   logic [AW-1:0]   w_ls_addr;

   // A store granted this very cycle must already be visible to the next load.
   assign w_st_grant = (r_state == ST_REQ) && r_mem_req && r_mem_we && mem_gnt;
   assign w_ls_valid = w_st_grant || r_ls_valid;
   assign w_ls_addr  = w_st_grant ? r_mem_addr : r_ls_addr;
   assign w_hit      = !w_nxt.is_store && w_ls_valid && (w_ls_addr == w_nxt.addr);
`else
   assign w_hit      = 1'b0;
`endif

   // Pop the head and, if another entry is already resident, reload from it.
   always_comb begin
      w_pop   = 1'b0;
      w_issue = 1'b0;
      w_nxt   = w_head;
      case (r_state)
         ST_IDLE: w_issue = !w_empty;
         ST_REQ: begin
`ifdef MEM_COMMIT_STORE_FWD_EN
            if (r_fwd || (mem_gnt && r_mem_we)) begin
`else
            if (mem_gnt && r_mem_we) begin
`endif
               w_pop   = 1'b1;
               w_issue = (w_count > CW'(1));
               w_nxt   = w_second;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               w_pop   = 1'b1;
               w_issue = (w_count > CW'(1));
               w_nxt   = w_second;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_ld_regwrite <= 1'b0;
         r_ld_tag      <= '0;
         r_ld_wreg     <= '0;
         r_ld_result   <= '0;
`ifdef MEM_COMMIT_STORE_FWD_EN
         r_ls_valid    <= 1'b0;
         r_ls_addr     <= '0;
         r_ls_data     <= '0;
         r_fwd         <= 1'b0;
`endif
      end else begin
         r_ld_regwrite <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_issue) r_state <= ST_REQ;
            ST_REQ: begin
`ifdef MEM_COMMIT_STORE_FWD_EN
               if (r_fwd) begin
                  r_ld_regwrite <= 1'b1;
                  r_ld_result   <= r_ls_data;
                  r_ld_tag      <= w_head.tag;
                  r_ld_wreg     <= w_head.wreg;
                  r_state       <= w_issue ? ST_REQ : ST_IDLE;
               end else
`endif
               if (mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_state   <= r_mem_we ? (w_issue ? ST_REQ : ST_IDLE) : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  r_ld_regwrite <= 1'b1;
                  r_ld_result   <= mem_rdata;
                  r_ld_tag      <= w_head.tag;
                  r_ld_wreg     <= w_head.wreg;
                  r_state       <= w_issue ? ST_REQ : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
`ifdef MEM_COMMIT_STORE_FWD_EN
         if (w_st_grant) begin
            r_ls_valid <= 1'b1;
            r_ls_addr  <= r_mem_addr;
            r_ls_data  <= r_mem_wdata;
         end
         if (w_pop) r_fwd <= 1'b0;
         if (w_issue) r_fwd <= w_hit;
`endif
         if (w_issue) begin
            r_mem_req   <= !w_hit;
            r_mem_we    <= w_nxt.is_store;
            r_mem_addr  <= w_nxt.addr;
            r_mem_wdata <= w_nxt.data;
         end
      end
   end

   assign CacheReady = !w_full && !w_afull;
   assign mem_req    = r_mem_req;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign LdTag      = r_ld_tag;
   assign LdResult   = r_ld_result;
   assign LdWriteReg = r_ld_wreg;
   assign LdRegWrite = r_ld_regwrite;
   assign q_count    = w_count;

endmodule

// File: tb/tb_mem_commit_queue.sv
// Scoreboard bench for mem_commit_queue: directed stimulus pushes expected
// cache requests / load completions; a negedge monitor pops and compares.
module tb_mem_commit_queue;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic        ROBMWE = 1'b0;
   logic [31:0] ROBMWA = '0;
   logic [31:0] ROBMWD = '0;
   logic        ROBMRegWrite = 1'b0;
   logic [31:0] ROBMRA = '0;
   logic [3:0]  ROBMTag = '0;
   logic [4:0]  ROBMWriteReg = '0;
   logic        CacheReady;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [3:0]  LdTag;
   logic [31:0] LdResult;
   logic [4:0]  LdWriteReg;
   logic        LdRegWrite;
   logic [$clog2(DEPTH):0] q_count;

   typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
   typedef struct packed { logic [3:0] tag; logic [4:0] wreg; logic [31:0] data; } ld_t;

   req_t exp_req[$];
   ld_t  exp_ld[$];
   int   total = 0;
   int   bad = 0;

   mem_commit_queue #(.DEPTH(DEPTH), .AW(32)) dut (
      .CLK(CLK), .reset(reset),
      .ROBMWE(ROBMWE), .ROBMWA(ROBMWA), .ROBMWD(ROBMWD),
      .ROBMRegWrite(ROBMRegWrite), .ROBMRA(ROBMRA), .ROBMTag(ROBMTag), .ROBMWriteReg(ROBMWriteReg),
      .CacheReady(CacheReady),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .LdTag(LdTag), .LdResult(LdResult), .LdWriteReg(LdWriteReg), .LdRegWrite(LdRegWrite),
      .q_count(q_count)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle_outputs(input string tagname);
      check({tagname, "_mem_req"},   32'(mem_req), 32'd0);
      check({tagname, "_mem_we"},    32'(mem_we), 32'd0);
      check({tagname, "_mem_addr"},  mem_addr, 32'd0);
      check({tagname, "_mem_wdata"}, mem_wdata, 32'd0);
      check({tagname, "_ldwrite"},   32'(LdRegWrite), 32'd0);
      check({tagname, "_ldtag"},     32'(LdTag), 32'd0);
      check({tagname, "_ldreg"},     32'(LdWriteReg), 32'd0);
      check({tagname, "_ldresult"},  LdResult, 32'd0);
      check({tagname, "_cacheready"}, 32'(CacheReady), 32'd1);
      check({tagname, "_count"},     32'(q_count), 32'd0);
   endtask

   // Monitor: every accepted request and every load completion is scored.
   always @(negedge CLK) begin
      req_t r;
      ld_t  l;
      if (reset) begin
         if (mem_req && mem_gnt) begin
            if (exp_req.size() == 0) begin
               total++; bad++;
               $display("FAIL req_unexpected: got addr %h we %0d expected no request", mem_addr, mem_we);
            end else begin
               r = exp_req.pop_front();
               check("req_we", 32'(mem_we), 32'(r.we));
               check("req_addr", mem_addr, r.addr);
               check("req_wdata", mem_wdata, r.wdata);
            end
         end
         if (LdRegWrite) begin
            if (exp_ld.size() == 0) begin
               total++; bad++;
               $display("FAIL ld_unexpected: got tag %0d result %h expected no completion", LdTag, LdResult);
            end else begin
               l = exp_ld.pop_front();
               check("ld_tag", 32'(LdTag), 32'(l.tag));
               check("ld_wreg", 32'(LdWriteReg), 32'(l.wreg));
               check("ld_result", LdResult, l.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) tick();
      check_idle_outputs("reset");
      reset = 1'b1;
      tick();

      // Single store, grant tied high
      mem_gnt = 1'b1;
      ROBMWE = 1'b1; ROBMWA = 32'h100; ROBMWD = 32'hDEADBEEF;
      exp_req.push_back('{we: 1'b1, addr: 32'h100, wdata: 32'hDEADBEEF});
      tick();
      ROBMWE = 1'b0;
      check("st_count_after_enq", 32'(q_count), 32'd1);
      tick();
      check("st_req_latency", 32'(mem_req), 32'd1);
      tick();
      check("st_req_dropped", 32'(mem_req), 32'd0);
      check("st_count_drained", 32'(q_count), 32'd0);

      // Load with delayed grant and delayed data
      mem_gnt = 1'b0;
      ROBMRegWrite = 1'b1; ROBMRA = 32'h40; ROBMTag = 4'd7; ROBMWriteReg = 5'd9;
      exp_req.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
      exp_ld.push_back('{tag: 4'd7, wreg: 5'd9, data: 32'h12345678});
      tick();
      ROBMRegWrite = 1'b0;
      tick();
      tick();
      check("ld_req_held", 32'(mem_req), 32'd1);
      check("ld_addr_held", mem_addr, 32'h40);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      check("ld_req_after_gnt", 32'(mem_req), 32'd0);
      tick();
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_rvalid = 1'b0;
      check("ld_strobe", 32'(LdRegWrite), 32'd1);
      tick();
      check("ld_strobe_one_cycle", 32'(LdRegWrite), 32'd0);
      check("ld_count_drained", 32'(q_count), 32'd0);

      // Same-cycle store + load: store issues first
      mem_gnt = 1'b1;
      ROBMWE = 1'b1; ROBMWA = 32'h200; ROBMWD = 32'hA5;
      ROBMRegWrite = 1'b1; ROBMRA = 32'h204; ROBMTag = 4'd3; ROBMWriteReg = 5'd4;
      exp_req.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'hA5});
      exp_req.push_back('{we: 1'b0, addr: 32'h204, wdata: 32'h0});
      exp_ld.push_back('{tag: 4'd3, wreg: 5'd4, data: 32'hCAFE0001});
      tick();
      ROBMWE = 1'b0; ROBMRegWrite = 1'b0;
      check("dual_count_peak", 32'(q_count), 32'd2);
      check("dual_cacheready", 32'(CacheReady), 32'd1);
      tick();
      check("dual_first_is_store", 32'(mem_we), 32'd1);
      tick();
      check("dual_second_is_load", 32'(mem_we), 32'd0);
      check("dual_second_addr", mem_addr, 32'h204);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
      tick();
      mem_rvalid = 1'b0;
      check("dual_ld_strobe", 32'(LdRegWrite), 32'd1);
      tick();

      // Fill to DEPTH with grant low, then drain back-to-back
      mem_gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ROBMWE = 1'b1; ROBMWA = 32'h1000 + 32'(4 * k); ROBMWD = 32'h11110000 + 32'(k);
         exp_req.push_back('{we: 1'b1, addr: 32'h1000 + 32'(4 * k), wdata: 32'h11110000 + 32'(k)});
         tick();
         check("fill_count", 32'(q_count), 32'(k + 1));
         check("fill_cacheready", 32'(CacheReady), (k >= 2) ? 32'd0 : 32'd1);
      end
      ROBMWE = 1'b0;
      check("fill_head_addr", mem_addr, 32'h1000);
      mem_gnt = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("drain_count", 32'(q_count), 32'(3 - k));
         check("drain_cacheready", 32'(CacheReady), (k == 0) ? 32'd0 : 32'd1);
      end
      check("drain_req_off", 32'(mem_req), 32'd0);

      // Reset while waiting for load data
      ROBMRegWrite = 1'b1; ROBMRA = 32'h80; ROBMTag = 4'd5; ROBMWriteReg = 5'd6;
      exp_req.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0});
      tick();
      ROBMRegWrite = 1'b0;
      tick();
      tick();
      mem_gnt = 1'b0;
      check("rst_in_wait_req", 32'(mem_req), 32'd0);
      reset = 1'b0;
      #1;
      check_idle_outputs("midreset");
      #2;
      reset = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
      tick();
      mem_rvalid = 1'b0;
      check("stale_rvalid_ignored", 32'(LdRegWrite), 32'd0);
      check("stale_count", 32'(q_count), 32'd0);
      tick();

      // Store then load of the same address
      mem_gnt = 1'b1;
      ROBMWE = 1'b1; ROBMWA = 32'h300; ROBMWD = 32'h55;
      exp_req.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h55});
      tick();
      ROBMWE = 1'b0;
      tick();
      tick();
      ROBMRegWrite = 1'b1; ROBMRA = 32'h300; ROBMTag = 4'd2; ROBMWriteReg = 5'd8;
`ifdef MEM_COMMIT_STORE_FWD_EN
      exp_ld.push_back('{tag: 4'd2, wreg: 5'd8, data: 32'h55});
      tick();
      ROBMRegWrite = 1'b0;
      tick();
      check("fwd_no_req", 32'(mem_req), 32'd0);
      tick();
      check("fwd_strobe", 32'(LdRegWrite), 32'd1);
      check("fwd_no_req_after", 32'(mem_req), 32'd0);
`else
      exp_req.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0});
      exp_ld.push_back('{tag: 4'd2, wreg: 5'd8, data: 32'h77});
      tick();
      ROBMRegWrite = 1'b0;
      tick();
      check("nofwd_req", 32'(mem_req), 32'd1);
      check("nofwd_addr", mem_addr, 32'h300);
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h77;
      tick();
      mem_rvalid = 1'b0;
      check("nofwd_strobe", 32'(LdRegWrite), 32'd1);
`endif
      tick();
      tick();
      check("final_count", 32'(q_count), 32'd0);
      check("req_queue_left", 32'(exp_req.size()), 32'd0);
      check("ld_queue_left", 32'(exp_ld.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
